mc_ctrl_unit: RTL and testbench
===============================

MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15: max wait cycles for i_mem_ack before trap (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32: retired-instruction counter width.
REQ-003 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_instr  in  32  fetched instruction; valid only when i_mem_ack=1 in FETCH.
- i_mem_ack  in  1  memory completion strobe for the current request.
- i_br_less  in  1  comparator less-than.
- i_br_equal  in  1  comparator equal.
- o_mem_req  out  1  memory request, held until ack.
- o_mem_we  out  1  1=store, 0=read.
- o_ir_en  out  1  datapath instruction/PC latch enable.
- o_pc_en  out  1  PC update strobe.
- o_pc_sel  out  1  1=ALU target, 0=PC+4.
- o_rd_wren  out  1  regfile write enable.
- o_opa_sel  out  1  1=PC, 0=rs1.
- o_opb_sel  out  1  1=rs2, 0=immediate.
- o_alu_op  out  4  ALU op code.
- o_br_un  out  1  unsigned compare.
- o_data_type  out  2  00 word, 01 half, 10 byte, 11 none.
- o_unsigned  out  1  zero-extend load.
- o_wb_sel  out  2  00 mem, 01 ALU, 10 PC+4.
- o_insn_vld  out  1  one-cycle retire pulse.
- o_trap  out  1  sticky fault flag.
- o_trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 mem timeout.
- o_retired  out  CNT_W  retired-instruction count.

Function
REQ-004 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs decoded from state plus internal 32-bit IR register.
REQ-005 FETCH: o_mem_req=1, o_mem_we=0; on i_mem_ack latch i_instr into IR, pulse o_ir_en, go DECODE.
REQ-006 DECODE (1 cycle): opcodes 0110011, 0010011, 0110111, 0010111, 0000011, 0100011, 1100011, 1101111, 1100111 go EXEC; any other opcode goes TRAP, cause 01.
REQ-007 EXEC (1 cycle) drives o_alu_op/o_opa_sel/o_opb_sel per opcode.
- R: opb_sel=1; f3 000 -> 0000 (ADD, f7=0) / 0001 (SUB); 001 -> 0111; 010 -> 0010; 011 -> 0011; 100 -> 0100; 101 -> 1000 (f7=0) / 1001; 110 -> 0101; 111 -> 0110.
- I-ALU: same mapping except f3 000 always 0000.
- LUI: 1111. AUIPC/JAL/branch: opa_sel=1, ADD. Load/store/JALR: ADD.
REQ-008 EXEC SHALL register branch-taken: BEQ eq; BNE !eq; BLT less; BGE !less; BLTU/BGEU same with o_br_un=1; f3 010/011 never taken.
REQ-009 From EXEC: load/store go MEM; all others go WB.
REQ-010 MEM: o_mem_req=1, o_mem_we=1 for store; o_data_type f3 000 -> 10, 001 -> 01, 010 -> 00, other -> 00; o_unsigned=1 for load f3 100/101 (types 10/01); go WB on ack.
REQ-011 WB (1 cycle): o_pc_en=1, o_insn_vld=1, o_retired+1 (wraps at 2^CNT_W); o_rd_wren=1 for all except store/branch; o_pc_sel=1 for JAL, JALR, taken branch; o_wb_sel 00 load, 10 JAL/JALR, 01 otherwise; return FETCH.
REQ-012 Wait counter clears on entering FETCH/MEM, increments each cycle without ack; reaching TIMEOUT_CYC without ack goes TRAP, cause 10 (FETCH) or 11 (MEM).
REQ-013 Ack in the same cycle the counter reaches TIMEOUT_CYC SHALL win (no trap).
REQ-014 i_mem_ack outside FETCH/MEM SHALL be ignored.
REQ-015 TRAP: o_trap=1, all enables/requests 0, cause held; exit only by reset.
REQ-016 Outside the driving state, each output SHALL hold its reset value.

Reset
REQ-017 i_rst_n=0 SHALL immediately force state FETCH, IR=0, wait counter=0, o_retired=0, o_trap=0, o_trap_cause=00, o_data_type=11, o_wb_sel=00, o_alu_op=0000, all 1-bit outputs 0 -- mid-operation included.
REQ-018 First o_mem_req SHALL assert in the first cycle after reset release.

Verification
REQ-019 ADD x3,x1,x2 (0x002081B3), ack in 1st FETCH cycle -> o_alu_op=0000, o_opb_sel=1; WB 4 cycles after req; o_rd_wren=1, o_wb_sel=01, o_retired=1.
REQ-020 LBU (f3 100), MEM ack after 3 cycles -> o_data_type=10, o_unsigned=1; WB o_wb_sel=00, o_rd_wren=1.
REQ-021 BGEU with i_br_less=0 -> o_br_un=1; WB o_pc_sel=1, o_rd_wren=0; same with i_br_less=1 -> o_pc_sel=0.
REQ-022 Opcode 0x7F -> TRAP after DECODE, o_trap_cause=01, o_insn_vld never pulses; no exit until reset.
REQ-023 No ack for 15 FETCH cycles -> TRAP, cause 10; rerun with ack on 15th cycle -> no trap.
REQ-024 Reset asserted during MEM of a store -> o_mem_req drops asynchronously; after release FETCH, o_retired=0.

Source files
------------

// File: rtl/mc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// mc_ctrl_unit
//   Multi-cycle RV32I-style control unit. It sequences
//   FETCH -> DECODE -> EXEC -> (MEM) -> WB and falls into a sticky TRAP
//   state on an illegal opcode or a memory handshake timeout.
//   All control outputs are decoded from the current state and the
//   latched instruction register (IR).
//
// Ports
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_instr            fetched instruction; sampled on i_mem_ack in FETCH
//   i_mem_ack          memory completion strobe (honoured in FETCH/MEM only)
//   i_br_less/equal    branch comparator results, sampled in EXEC
//   o_mem_req/we       memory request / store select
//   o_ir_en            IR/PC latch enable; pulses with the fetch ack
//   o_pc_en/o_pc_sel   PC update strobe / ALU-target select (WB)
//   o_rd_wren          register file write enable (WB)
//   o_opa_sel/opb_sel  ALU operand selects (EXEC)
//   o_alu_op           ALU operation (EXEC)
//   o_br_un            unsigned branch compare (EXEC)
//   o_data_type        00 word, 01 half, 10 byte, 11 none (MEM)
//   o_unsigned         zero-extend load (MEM)
//   o_wb_sel           00 mem, 01 ALU, 10 PC+4 (WB)
//   o_insn_vld         one-cycle retire pulse (WB)
//   o_trap/cause       sticky fault flag and its cause
//   o_retired          retired-instruction count
// ---------------------------------------------------------------------------
module mc_ctrl_unit #(
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int          CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_instr,
  input  logic             i_mem_ack,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_ir_en,
  output logic             o_pc_en,
  output logic             o_pc_sel,
  output logic             o_rd_wren,
  output logic             o_opa_sel,
  output logic             o_opb_sel,
  output logic [3:0]       o_alu_op,
  output logic             o_br_un,
  output logic [1:0]       o_data_type,
  output logic             o_unsigned,
  output logic [1:0]       o_wb_sel,
  output logic             o_insn_vld,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // The wait counter holds the number of ack-less cycles already spent,
  // so the TIMEOUT_CYC-th cycle without ack is the one where it equals LAST.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [1:0]       cause_q, cause_d;
  logic             taken_q, taken_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b;
  logic       is_load, is_store, is_br, is_jal, is_jalr;

  assign opcode   = ir_q[6:0];
  assign f3       = ir_q[14:12];
  assign f7b      = ir_q[30];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);

  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  // Shared R/I ALU mapping; alt selects SUB / SRA variants.
  function automatic logic [3:0] alu_map(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  alu_map = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_map = 4'b0111;
      3'b010:  alu_map = 4'b0010;
      3'b011:  alu_map = 4'b0011;
      3'b100:  alu_map = 4'b0100;
      3'b101:  alu_map = alt ? 4'b1001 : 4'b1000;
      3'b110:  alu_map = 4'b0101;
      default: alu_map = 4'b0110;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      cause_q   <= 2'b00;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
      taken_q   <= taken_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    wait_d      = wait_q;
    retired_d   = retired_q;
    cause_d     = cause_q;
    taken_d     = taken_q;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_ir_en     = 1'b0;
    o_pc_en     = 1'b0;
    o_pc_sel    = 1'b0;
    o_rd_wren   = 1'b0;
    o_opa_sel   = 1'b0;
    o_opb_sel   = 1'b0;
    o_alu_op    = 4'b0000;
    o_br_un     = 1'b0;
    o_data_type = 2'b11;
    o_unsigned  = 1'b0;
    o_wb_sel    = 2'b00;
    o_insn_vld  = 1'b0;
    o_trap      = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Reset parks the FSM in FETCH; masking with i_rst_n keeps the
        // request low while reset is held instead of waiting for a clock.
        o_mem_req = i_rst_n;
        if (i_mem_ack) begin
          o_ir_en = i_rst_n;
          ir_d    = i_instr;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
          OP_BR, OP_JAL, OP_JALR: state_d = S_EXEC;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end

      S_EXEC: begin
        case (opcode)
          OP_R: begin
            o_opb_sel = 1'b1;
            o_alu_op  = alu_map(f3, f7b);
          end
          OP_I:   o_alu_op = alu_map(f3, f7b && (f3 == 3'b101));
          OP_LUI: o_alu_op = 4'b1111;
          OP_AUIPC, OP_JAL, OP_BR: o_opa_sel = 1'b1;
          default: ;
        endcase
        if (is_br) o_br_un = f3[2] & f3[1];
        taken_d = 1'b0;
        if (is_br) begin
          case (f3)
            3'b000:  taken_d = i_br_equal;
            3'b001:  taken_d = ~i_br_equal;
            3'b100, 3'b110: taken_d = i_br_less;
            3'b101, 3'b111: taken_d = ~i_br_less;
            default: taken_d = 1'b0;
          endcase
        end
        if (is_load || is_store) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = is_store;
        // f3[1:0] alone selects the size: LBU/LHU share it with LB/LH.
        case (f3[1:0])
          2'b00:   o_data_type = 2'b10;
          2'b01:   o_data_type = 2'b01;
          default: o_data_type = 2'b00;
        endcase
        o_unsigned = is_load & f3[2] & ~f3[1];
        if (i_mem_ack) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB: begin
        o_pc_en    = 1'b1;
        o_insn_vld = 1'b1;
        retired_d  = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        o_rd_wren  = ~(is_store | is_br);
        o_pc_sel   = is_jal | is_jalr | (is_br & taken_q);
        if (is_load)                o_wb_sel = 2'b00;
        else if (is_jal || is_jalr) o_wb_sel = 2'b10;
        else                        o_wb_sel = 2'b01;
        state_d = S_FETCH;
        wait_d  = '0;
      end

      S_TRAP: o_trap = 1'b1;

      default: state_d = S_TRAP;
    endcase
  end

  assign o_trap_cause = cause_q;
  assign o_retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
module tb_mc_ctrl_unit;

  logic        i_clk, i_rst_n;
  logic [31:0] i_instr;
  logic        i_mem_ack, i_br_less, i_br_equal;
  logic        o_mem_req, o_mem_we, o_ir_en, o_pc_en, o_pc_sel, o_rd_wren;
  logic        o_opa_sel, o_opb_sel, o_br_un, o_unsigned, o_insn_vld, o_trap;
  logic [3:0]  o_alu_op;
  logic [1:0]  o_data_type, o_wb_sel, o_trap_cause;
  logic [31:0] o_retired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pc_sel;
    logic        rd_wren;
    logic [1:0]  wb_sel;
    logic [31:0] retired;
  } wb_exp_t;

  wb_exp_t     sb[$];
  logic [31:0] exp_retired;

  mc_ctrl_unit #(.TIMEOUT_CYC(15), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_mem_ack(i_mem_ack),
    .i_br_less(i_br_less), .i_br_equal(i_br_equal),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_ir_en(o_ir_en),
    .o_pc_en(o_pc_en), .o_pc_sel(o_pc_sel), .o_rd_wren(o_rd_wren),
    .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_alu_op(o_alu_op),
    .o_br_un(o_br_un), .o_data_type(o_data_type), .o_unsigned(o_unsigned),
    .o_wb_sel(o_wb_sel), .o_insn_vld(o_insn_vld), .o_trap(o_trap),
    .o_trap_cause(o_trap_cause), .o_retired(o_retired)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at (negedge + small delay); releases reset at the next negedge.
  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    sb.delete();
    exp_retired = 32'd0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_mem_ack = 1'b1; i_instr = 32'h002081B3;
    i_br_less = 1'b0; i_br_equal = 1'b0;
    exp_retired = 32'd0;
    @(negedge i_clk); #1;
    checks++;
    if ({o_mem_req, o_mem_we, o_ir_en, o_pc_en, o_pc_sel, o_rd_wren, o_opa_sel,
         o_opb_sel, o_br_un, o_unsigned, o_insn_vld, o_trap} !== 12'b0) begin
      errors++; $display("FAIL reset_bits: got %b required all 0",
        {o_mem_req, o_mem_we, o_ir_en, o_pc_en, o_pc_sel, o_rd_wren, o_opa_sel,
         o_opb_sel, o_br_un, o_unsigned, o_insn_vld, o_trap});
    end
    checks++;
    if ({o_data_type, o_wb_sel, o_alu_op, o_trap_cause} !== {2'b11, 2'b00, 4'b0000, 2'b00}) begin
      errors++; $display("FAIL reset_fields: got dt=%b wb=%b alu=%b cause=%b required 11 00 0000 00",
        o_data_type, o_wb_sel, o_alu_op, o_trap_cause);
    end
    checks++;
    if (o_retired !== 32'd0) begin
      errors++; $display("FAIL reset_retired: got %0d required 0", o_retired);
    end
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checks++;
    if (o_mem_req !== 1'b1) begin
      errors++; $display("FAIL first_req: got %b required 1", o_mem_req);
    end
    $display("txn reset done");
  endtask

  // Runs one instruction from FETCH to the start of the next FETCH.
  task automatic run_instr(
    input string name, input logic [31:0] instr,
    input int fetch_wait, input int mem_wait,
    input logic less, input logic eq, input logic ack_noise,
    input logic [3:0] e_alu, input logic e_opa, input logic e_opb, input logic e_brun,
    input logic is_mem, input logic e_we, input logic [1:0] e_dt, input logic e_uns,
    input logic e_pcsel, input logic e_rdwren, input logic [1:0] e_wbsel);
    wb_exp_t e;
    e.pc_sel = e_pcsel; e.rd_wren = e_rdwren; e.wb_sel = e_wbsel;
    e.retired = exp_retired + 32'd1;
    exp_retired = exp_retired + 32'd1;
    sb.push_back(e);

    checks++;
    if ({o_mem_req, o_mem_we, o_trap} !== 3'b100) begin
      errors++; $display("FAIL %s fetch_req: got req/we/trap=%b required 100", name, {o_mem_req, o_mem_we, o_trap});
    end
    i_mem_ack = 1'b0;
    repeat (fetch_wait) @(negedge i_clk);
    i_instr = instr; i_mem_ack = 1'b1;
    #1;
    checks++;
    if (o_ir_en !== 1'b1) begin
      errors++; $display("FAIL %s ir_en: got %b required 1", name, o_ir_en);
    end
    @(negedge i_clk);
    i_mem_ack = ack_noise; i_instr = 32'hFFFF_FFFF;
    @(negedge i_clk);
    i_br_less = less; i_br_equal = eq;
    #1;
    checks++;
    if ({o_alu_op, o_opa_sel, o_opb_sel, o_br_un} !== {e_alu, e_opa, e_opb, e_brun}) begin
      errors++; $display("FAIL %s exec: got alu/opa/opb/brun=%b required %b", name,
        {o_alu_op, o_opa_sel, o_opb_sel, o_br_un}, {e_alu, e_opa, e_opb, e_brun});
    end
    @(negedge i_clk);
    i_mem_ack = 1'b0; i_br_less = ~less; i_br_equal = ~eq;
    if (is_mem) begin
      checks++;
      if ({o_mem_req, o_mem_we, o_data_type, o_unsigned} !== {1'b1, e_we, e_dt, e_uns}) begin
        errors++; $display("FAIL %s mem: got req/we/dt/uns=%b required %b", name,
          {o_mem_req, o_mem_we, o_data_type, o_unsigned}, {1'b1, e_we, e_dt, e_uns});
      end
      repeat (mem_wait) @(negedge i_clk);
      i_mem_ack = 1'b1;
      @(negedge i_clk);
      i_mem_ack = 1'b0;
    end
    checks++;
    if (o_insn_vld !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL %s wb_pulse: got insn_vld=%b queue=%0d required 1 and non-empty", name, o_insn_vld, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({o_pc_en, o_pc_sel, o_rd_wren, o_wb_sel} !== {1'b1, e.pc_sel, e.rd_wren, e.wb_sel}) begin
        errors++; $display("FAIL %s wb: got pc_en/pc_sel/rd_wren/wb_sel=%b required %b", name,
          {o_pc_en, o_pc_sel, o_rd_wren, o_wb_sel}, {1'b1, e.pc_sel, e.rd_wren, e.wb_sel});
      end
      @(negedge i_clk);
      checks++;
      if (o_retired !== e.retired || o_insn_vld !== 1'b0) begin
        errors++; $display("FAIL %s retired: got %0d vld=%b required %0d vld=0", name, o_retired, o_insn_vld, e.retired);
      end
    end
    $display("txn %s instr=%h retired=%0d", name, instr, o_retired);
  endtask

  task automatic test_alu();
    //        name    instr         fw mw lt eq nz alu    a  b  un mem we dt    u  pc rd wb
    run_instr("ADD",  32'h002081B3, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("SUB",  32'h402081B3, 2, 0, 0, 0, 0, 4'h1, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("SLL",  32'h002091B3, 0, 0, 0, 0, 0, 4'h7, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("SRA",  32'h4020D1B3, 0, 0, 0, 0, 0, 4'h9, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("SLTU", 32'h0020B1B3, 0, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("ADDI", 32'h40000093, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("SRAI", 32'h4010D093, 0, 0, 0, 0, 0, 4'h9, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("ORI",  32'h0000E093, 0, 0, 0, 0, 0, 4'h5, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("LUI",  32'h000010B7, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("AUIPC",32'h00001097, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
  endtask

  task automatic test_jump();
    run_instr("JAL",  32'h0080006F, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 2'b11, 0, 1, 1, 2'b10);
    run_instr("JALR", 32'h00008067, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 0, 1, 1, 2'b10);
  endtask

  task automatic test_mem();
    run_instr("LBU",  32'h00014083, 0, 3, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 2'b10, 1, 0, 1, 2'b00);
    run_instr("LH",   32'h00011083, 0, 14,0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 2'b01, 0, 0, 1, 2'b00);
    run_instr("LW",   32'h00012083, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 2'b00);
    run_instr("SW",   32'h00112023, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 2'b01);
    run_instr("SB",   32'h00110023, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 1, 2'b10, 0, 0, 0, 2'b01);
  endtask

  task automatic test_branch();
    run_instr("BGEU_t", 32'h00117063, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0, 0, 2'b11, 0, 1, 0, 2'b01);
    run_instr("BGEU_n", 32'h00117063, 0, 0, 1, 0, 0, 4'h0, 1, 0, 1, 0, 0, 2'b11, 0, 0, 0, 2'b01);
    run_instr("BEQ_t",  32'h00110063, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 0, 0, 2'b11, 0, 1, 0, 2'b01);
    run_instr("BNE_n",  32'h00111063, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b01);
    run_instr("BLT_t",  32'h00114063, 0, 0, 1, 0, 0, 4'h0, 1, 0, 0, 0, 0, 2'b11, 0, 1, 0, 2'b01);
    run_instr("BR010",  32'h00112063, 0, 0, 1, 1, 0, 4'h0, 1, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b01);
  endtask

  task automatic test_back_to_back();
    // Ack held high through DECODE/EXEC must be ignored.
    run_instr("ADDn1", 32'h002081B3, 0, 0, 0, 0, 1, 4'h0, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    run_instr("SWn",   32'h00112023, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 2'b01);
    run_instr("ADDn2", 32'h402081B3, 0, 0, 0, 0, 1, 4'h1, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
  endtask

  task automatic test_illegal();
    logic bad;
    apply_reset();
    i_instr = 32'h0000007F; i_mem_ack = 1'b1;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    @(negedge i_clk); #1;
    checks++;
    if ({o_trap, o_trap_cause, o_mem_req} !== {1'b1, 2'b01, 1'b0}) begin
      errors++; $display("FAIL illegal_trap: got trap/cause/req=%b required 1010", {o_trap, o_trap_cause, o_mem_req});
    end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      i_mem_ack = i[0]; i_instr = 32'h002081B3;
      #1;
      if (o_insn_vld || !o_trap || o_trap_cause != 2'b01 || o_mem_req || o_pc_en || o_ir_en) bad = 1'b1;
      @(negedge i_clk);
    end
    i_mem_ack = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL illegal_sticky: got violation=%b required 0", bad);
    end
    apply_reset();
    checks++;
    if ({o_trap, o_trap_cause, o_mem_req} !== 4'b0001) begin
      errors++; $display("FAIL illegal_exit: got trap/cause/req=%b required 0001", {o_trap, o_trap_cause, o_mem_req});
    end
    $display("txn illegal opcode trap");
  endtask

  task automatic test_timeout();
    logic bad;
    apply_reset();
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (o_mem_req !== 1'b1 || o_trap !== 1'b0) bad = 1'b1;
      @(negedge i_clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL fetch_wait: got early_exit=%b required 0", bad);
    end
    checks++;
    if ({o_trap, o_trap_cause, o_mem_req} !== {1'b1, 2'b10, 1'b0}) begin
      errors++; $display("FAIL fetch_timeout: got trap/cause/req=%b required 1100", {o_trap, o_trap_cause, o_mem_req});
    end
    $display("txn fetch timeout");
    apply_reset();
    run_instr("ADD_f15", 32'h002081B3, 14, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    checks++;
    if (o_trap !== 1'b0) begin
      errors++; $display("FAIL fetch_ack_wins: got trap=%b required 0", o_trap);
    end
    // MEM timeout: load with no ack for 15 MEM cycles.
    i_instr = 32'h00012083; i_mem_ack = 1'b1;
    @(negedge i_clk); i_mem_ack = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    repeat (15) @(negedge i_clk);
    checks++;
    if ({o_trap, o_trap_cause, o_mem_req} !== {1'b1, 2'b11, 1'b0}) begin
      errors++; $display("FAIL mem_timeout: got trap/cause/req=%b required 1110", {o_trap, o_trap_cause, o_mem_req});
    end
    $display("txn mem timeout");
  endtask

  task automatic test_reset_in_mem();
    apply_reset();
    run_instr("ADD_pre", 32'h002081B3, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
    i_instr = 32'h00112023; i_mem_ack = 1'b1;
    @(negedge i_clk); i_mem_ack = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    @(negedge i_clk); #1;
    checks++;
    if ({o_mem_req, o_mem_we} !== 2'b11) begin
      errors++; $display("FAIL store_mem: got req/we=%b required 11", {o_mem_req, o_mem_we});
    end
    #1 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_mem_req, o_mem_we, o_data_type, o_retired} !== {1'b0, 1'b0, 2'b11, 32'd0}) begin
      errors++; $display("FAIL async_reset: got req=%b we=%b dt=%b retired=%0d required 0 0 11 0",
        o_mem_req, o_mem_we, o_data_type, o_retired);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    sb.delete(); exp_retired = 32'd0;
    #1;
    checks++;
    if ({o_mem_req, o_mem_we, o_trap} !== 3'b100 || o_retired !== 32'd0) begin
      errors++; $display("FAIL after_reset: got req/we/trap=%b retired=%0d required 100 0", {o_mem_req, o_mem_we, o_trap}, o_retired);
    end
    $display("txn reset during store MEM");
    run_instr("ADD_post", 32'h002081B3, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 2'b01);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jump();
    test_mem();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_in_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
